memory_responder: RTL

MEMORY_RESPONDER -- requirements
Module: memory_responder

---
 rtl/memory_responder_if.sv | 29 ++
 rtl/memory_responder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/memory_responder_if.sv
// Request/response bundle between a memory requester and memory_responder.
// Each field is packed per channel so one instance serves every channel.
interface memory_responder_if #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 16,
  parameter int NUM_CHANNELS = 1
);
  logic [NUM_CHANNELS-1:0]                mem_read_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
  logic [NUM_CHANNELS-1:0]                mem_read_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;
  logic [NUM_CHANNELS-1:0]                mem_write_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
  logic [NUM_CHANNELS-1:0]                mem_write_ready;
  logic [NUM_CHANNELS-1:0]                channel_busy;

  modport master (
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready, channel_busy
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready, channel_busy
  );
endinterface

// File: rtl/memory_responder.sv
// Fixed-latency memory model: per-channel request FSMs sharing one array,
// reads served before writes, lowest channel wins same-edge write conflicts.
module memory_responder #(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 16,
  parameter int NUM_CHANNELS  = 1,
  parameter int READ_LATENCY  = 3,
  parameter int WRITE_LATENCY = 3
) (
  input logic               clk,
  input logic               reset,
  memory_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    WRITE_WAIT,
    RESPOND,
    RELEASE
  } state_t;

  logic [DATA_BITS-1:0]                   r_mem [DEPTH];
  logic [NUM_CHANNELS-1:0]                w_commit;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] w_ch_addr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] w_ch_wdata;

  // Highest channel is applied first so the lowest index lands last and wins.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
      if (w_commit[NUM_CHANNELS-1-k])
        r_mem[w_ch_addr[NUM_CHANNELS-1-k]] <= w_ch_wdata[NUM_CHANNELS-1-k];
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [ADDR_BITS-1:0] r_addr;
    logic [DATA_BITS-1:0] r_wdata;
    logic [DATA_BITS-1:0] r_rdata;
    logic                 r_is_read;
    logic                 w_rv, w_wv;
    logic                 w_cap_rd, w_cap_wr, w_rload;
    logic                 w_rd_rdy, w_wr_rdy, w_busy;

    assign w_rv = bus.mem_read_valid[g];
    assign w_wv = bus.mem_write_valid[g];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state   <= IDLE;
        r_cnt     <= '0;
        r_addr    <= '0;
        r_wdata   <= '0;
        r_is_read <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        if (w_cap_rd) begin
          r_addr    <= bus.mem_read_address[g];
          r_is_read <= 1'b1;
        end else if (w_cap_wr) begin
          r_addr    <= bus.mem_write_address[g];
          r_wdata   <= bus.mem_write_data[g];
          r_is_read <= 1'b0;
        end
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cap_rd    = 1'b0;
      w_cap_wr    = 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rv) begin
            w_state_nxt = READ_WAIT;
            w_cnt_nxt   = CNT_W'(READ_LATENCY);
            w_cap_rd    = 1'b1;
          end else if (w_wv) begin
            w_state_nxt = WRITE_WAIT;
            w_cnt_nxt   = CNT_W'(WRITE_LATENCY);
            w_cap_wr    = 1'b1;
          end
        end
        READ_WAIT, WRITE_WAIT: begin
          if (!((r_state == READ_WAIT) ? w_rv : w_wv)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = RESPOND;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        RESPOND: w_state_nxt = RELEASE;
        RELEASE: begin
          if (!(r_is_read ? w_rv : w_wv))
            w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    always_comb begin
      w_busy   = (r_state != IDLE);
      w_rd_rdy = (r_state == RESPOND) && r_is_read;
      w_wr_rdy = (r_state == RESPOND) && !r_is_read;
    end

    assign w_rload     = (r_state == READ_WAIT)  && (w_state_nxt == RESPOND);
    assign w_commit[g] = (r_state == WRITE_WAIT) && (w_state_nxt == RESPOND);
    assign w_ch_addr[g]  = r_addr;
    assign w_ch_wdata[g] = r_wdata;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        r_rdata <= '0;
      else if (w_rload)
        r_rdata <= r_mem[r_addr];
    end

    assign bus.mem_read_data[g]   = r_rdata;
    assign bus.mem_read_ready[g]  = w_rd_rdy;
    assign bus.mem_write_ready[g] = w_wr_rdy;
    assign bus.channel_busy[g]    = w_busy;
  end

endmodule
